// File: rtl/tx_buffer_pkg.sv
// Shared defaults and FSM encoding for the packet-committing TX buffer.
package tx_buffer_pkg;
  localparam int PKT_LEN_DEF = 256;
  localparam int AW_DEF      = 10;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;
endpackage

// File: rtl/tx_dpram.sv
// Simple dual-port RAM: one write port, one read port with a registered output.
module tx_dpram #(
  parameter int AW = 10,
  parameter int DW = 16
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);
  logic [DW-1:0] mem_q [2**AW];
  logic [DW-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;
endmodule

// File: rtl/tx_buffer.sv
// Host-to-TX FIFO that only exposes whole packets to the consumer.
// Define TX_BUFFER_DEBUG_EN to drive debugbus with state, flags and committed count.
module tx_buffer
  import tx_buffer_pkg::*;
#(
  parameter int PKT_LEN = PKT_LEN_DEF,
  parameter int AW      = AW_DEF
) (
  input  logic        usbclk,
  input  logic        rst,
  input  logic [15:0] usbdata,
  input  logic        WR,
  output logic        have_space,
  output logic        tx_underrun,
  output logic        tx_overrun,
  input  logic        clear_status,
  input  logic        txstrobe,
  output logic [15:0] txdata,
  output logic        txvalid,
  output logic [15:0] debugbus
);
  localparam int DEPTH = 2**AW;
  localparam int CW    = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;

  typedef logic [AW:0] ptr_t;

  ptr_t          wr_ptr_q, wr_ptr_d, com_ptr_q, com_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] wcnt_q, wcnt_d;
  logic [0:0]    state_q, state_d;
  logic          ovr_q, ovr_d, und_q, und_d, hs_q, hs_d;
  logic          vld_q, vld_d, zero_q, zero_d;
  ptr_t          used, committed, used_d;
  logic [AW+1:0] free_d;
  logic          full, wr_en, pop, under;
  logic [15:0]   ram_rdata;

  assign used      = wr_ptr_q - rd_ptr_q;
  assign committed = com_ptr_q - rd_ptr_q;
  assign full      = (used == ptr_t'(DEPTH));
  assign wr_en     = WR && !full;
  assign pop       = (state_q == ST_RUN) && txstrobe && (committed != '0);
  assign under     = (state_q == ST_RUN) && txstrobe && (committed == '0);

  always_comb begin
    wr_ptr_d  = wr_ptr_q + ptr_t'(wr_en);
    rd_ptr_d  = rd_ptr_q + ptr_t'(pop);
    com_ptr_d = com_ptr_q;
    wcnt_d    = wcnt_q;
    if (wr_en) begin
      if (wcnt_q == CW'(PKT_LEN-1)) begin
        wcnt_d    = '0;
        com_ptr_d = com_ptr_q + ptr_t'(PKT_LEN);
      end else begin
        wcnt_d = wcnt_q + CW'(1);
      end
    end

    state_d = state_q;
    if (state_q == ST_IDLE) begin
      if (committed >= ptr_t'(PKT_LEN)) state_d = ST_RUN;
    end else if (under) begin
      state_d = ST_IDLE;
    end

    // a fresh event beats clear_status in the same cycle
    ovr_d = (ovr_q && !clear_status) || (WR && full);
    und_d = (und_q && !clear_status) || under;

    vld_d  = pop;
    zero_d = under ? 1'b1 : (pop ? 1'b0 : zero_q);

    used_d = wr_ptr_d - rd_ptr_d;
    free_d = (AW+2)'(DEPTH) - {1'b0, used_d};
    hs_d   = (free_d >= (AW+2)'(PKT_LEN));
  end

  always_ff @(posedge usbclk or posedge rst) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      com_ptr_q <= '0;
      rd_ptr_q  <= '0;
      wcnt_q    <= '0;
      state_q   <= ST_IDLE;
      ovr_q     <= 1'b0;
      und_q     <= 1'b0;
      hs_q      <= 1'b1;
      vld_q     <= 1'b0;
      zero_q    <= 1'b1;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      com_ptr_q <= com_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      wcnt_q    <= wcnt_d;
      state_q   <= state_d;
      ovr_q     <= ovr_d;
      und_q     <= und_d;
      hs_q      <= hs_d;
      vld_q     <= vld_d;
      zero_q    <= zero_d;
    end
  end

  tx_dpram #(.AW(AW), .DW(16)) u_ram (
    .clk_i   (usbclk),
    .we_i    (wr_en),
    .waddr_i (wr_ptr_q[AW-1:0]),
    .wdata_i (usbdata),
    .re_i    (pop),
    .raddr_i (rd_ptr_q[AW-1:0]),
    .rdata_o (ram_rdata)
  );

  // RAM output is masked to zero after reset or an underrun until the next pop
  assign txdata      = zero_q ? 16'h0 : ram_rdata;
  assign txvalid     = vld_q;
  assign have_space  = hs_q;
  assign tx_overrun  = ovr_q;
  assign tx_underrun = und_q;

`ifdef TX_BUFFER_DEBUG_EN
  assign debugbus = {state_q, ovr_q, und_q, 4'b0, committed[8:0]};
`else
  assign debugbus = '0;
`endif
endmodule

// File: tb/tb_tx_buffer.sv
// Self-checking bench for tx_buffer: directed sequences, a vector table and a random stream vs a queue model.
module tb_tx_buffer;
  localparam int PKT_LEN = 256;
  localparam int AW      = 10;
  localparam int DEPTH   = 2**AW;

  logic        usbclk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] usbdata = '0;
  logic        WR = 1'b0;
  logic        have_space, tx_underrun, tx_overrun;
  logic        clear_status = 1'b0;
  logic        txstrobe = 1'b0;
  logic [15:0] txdata;
  logic        txvalid;
  logic [15:0] debugbus;

  tx_buffer #(.PKT_LEN(PKT_LEN), .AW(AW)) dut (
    .usbclk(usbclk), .rst(rst), .usbdata(usbdata), .WR(WR),
    .have_space(have_space), .tx_underrun(tx_underrun), .tx_overrun(tx_overrun),
    .clear_status(clear_status), .txstrobe(txstrobe), .txdata(txdata),
    .txvalid(txvalid), .debugbus(debugbus)
  );

  always #5 usbclk = ~usbclk;

  int checks = 0;
  int errors = 0;
  int rx_cnt = 0;
  logic [15:0] last_rx = '0;

  // reference model: committed words, partial packet, FSM mode and flags
  logic [15:0] com[$];
  logic [15:0] part[$];
  bit          m_run, m_ovr, m_und, m_vld, m_hs;
  logic [15:0] m_data;

  typedef struct {
    bit w;
    bit c;
    bit e_ovr;
    bit e_hs;
  } vec_t;
  vec_t tbl[5];

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    com.delete();
    part.delete();
    m_run = 0; m_ovr = 0; m_und = 0; m_vld = 0; m_hs = 1; m_data = '0;
  endtask

  task automatic model(input bit w, input logic [15:0] d, input bit s, input bit c);
    int ncom = com.size();
    int tot  = com.size() + part.size();
    bit oe = 0, ue = 0;
    m_vld = 0;
    if (m_run) begin
      if (s) begin
        if (ncom > 0) begin
          m_data = com.pop_front();
          m_vld  = 1;
        end else begin
          ue = 1; m_data = '0; m_run = 0;
        end
      end
    end else if (ncom >= PKT_LEN) begin
      m_run = 1;
    end
    if (w) begin
      if (tot == DEPTH) oe = 1;
      else begin
        part.push_back(d);
        if (part.size() == PKT_LEN) begin
          foreach (part[i]) com.push_back(part[i]);
          part.delete();
        end
      end
    end
    m_ovr = (c ? 1'b0 : m_ovr) | oe;
    m_und = (c ? 1'b0 : m_und) | ue;
    m_hs  = (DEPTH - (com.size() + part.size())) >= PKT_LEN;
  endtask

  task automatic compare();
    chk("txvalid", txvalid, m_vld);
    chk("txdata", txdata, m_data);
    chk("tx_overrun", tx_overrun, m_ovr);
    chk("tx_underrun", tx_underrun, m_und);
    chk("have_space", have_space, m_hs);
`ifdef TX_BUFFER_DEBUG_EN
    chk("debugbus", debugbus, {m_run, m_ovr, m_und, 4'b0, 9'(com.size())});
`else
    chk("debugbus", debugbus, 16'h0);
`endif
    if (txvalid === 1'b1) begin
      rx_cnt++;
      last_rx = txdata;
    end
  endtask

  task automatic step(input bit w, input logic [15:0] d, input bit s, input bit c);
    WR = w; usbdata = d; txstrobe = s; clear_status = c;
    @(posedge usbclk);
    model(w, d, s, c);
    #1;
    compare();
  endtask

  task automatic do_reset();
    WR = 0; txstrobe = 0; clear_status = 0;
    rst = 1;
    #1;
    chk("rst_txvalid", txvalid, 16'h0);
    chk("rst_txdata", txdata, 16'h0);
    chk("rst_ovr", tx_overrun, 16'h0);
    chk("rst_und", tx_underrun, 16'h0);
    @(posedge usbclk);
    #1;
    model_reset();
    rst = 0;
    step(0, '0, 0, 0);
    chk("rst_have_space", have_space, 16'h1);
  endtask

  task automatic write_words(input int start, input int n);
    for (int i = 0; i < n; i++) begin
      step(1, 16'(start + i), 0, 0);
      if (i % 16 == 15) step(0, '0, 0, 0);
    end
  endtask

  task automatic drain(input int n, input int period);
    for (int i = 0; i < n; i++) begin
      step(0, '0, 1, 0);
      for (int k = 1; k < period; k++) step(0, '0, 0, 0);
    end
  endtask

  initial begin
    int base, wn, cyc;
    bit w, s;

    tbl[0] = '{w: 1, c: 0, e_ovr: 1, e_hs: 0};
    tbl[1] = '{w: 0, c: 0, e_ovr: 1, e_hs: 0};
    tbl[2] = '{w: 0, c: 1, e_ovr: 0, e_hs: 0};
    tbl[3] = '{w: 1, c: 1, e_ovr: 1, e_hs: 0};
    tbl[4] = '{w: 0, c: 1, e_ovr: 0, e_hs: 0};

    model_reset();
    repeat (2) @(posedge usbclk);
    #1;
    do_reset();

    // one packet written in bursts, drained every 4th cycle
    base = rx_cnt;
    write_words(0, 256);
    step(0, '0, 0, 0);
    drain(256, 4);
    chk("pkt_rx_count", 16'(rx_cnt - base), 16'd256);
    chk("pkt_last_word", last_rx, 16'd255);
    chk("pkt_no_ovr", tx_overrun, 16'h0);
    chk("pkt_no_und", tx_underrun, 16'h0);

    // partial packet is invisible until its last word lands
    do_reset();
    write_words(0, 255);
    step(0, '0, 1, 0);
    chk("partial_no_valid", txvalid, 16'h0);
    step(1, 16'd255, 0, 0);
    step(0, '0, 0, 0);
    step(0, '0, 1, 0);
    chk("commit_valid", txvalid, 16'h1);
    chk("commit_first_word", txdata, 16'h0);

    // fill to full, then overrun/clear vectors
    do_reset();
    write_words(0, 768);
    chk("space_at_768", have_space, 16'h1);
    step(1, 16'd768, 0, 0);
    chk("space_at_769", have_space, 16'h0);
    write_words(769, 255);
    for (int i = 0; i < 5; i++) begin
      step(tbl[i].w, 16'hDEAD, 0, tbl[i].c);
      chk("tbl_ovr", tx_overrun, 16'(tbl[i].e_ovr));
      chk("tbl_have_space", have_space, 16'(tbl[i].e_hs));
    end
    base = rx_cnt;
    drain(1024, 1);
    chk("full_rx_count", 16'(rx_cnt - base), 16'd1024);
    chk("full_last_word", last_rx, 16'd1023);

    // drain one packet, underrun on the 257th strobe, then resume
    do_reset();
    write_words(0, 256);
    step(0, '0, 0, 0);
    drain(256, 1);
    step(0, '0, 1, 0);
    chk("und_flag", tx_underrun, 16'h1);
    chk("und_txdata", txdata, 16'h0);
    chk("und_txvalid", txvalid, 16'h0);
    write_words(256, 256);
    step(0, '0, 0, 0);
    step(0, '0, 1, 0);
    chk("resume_word", txdata, 16'd256);
    step(0, '0, 0, 1);
    chk("und_cleared", tx_underrun, 16'h0);

    // reset mid-packet discards the partial words
    do_reset();
    write_words(0, 100);
    do_reset();
    write_words(1000, 256);
    step(0, '0, 0, 0);
    step(0, '0, 1, 0);
    chk("post_rst_first", txdata, 16'd1000);

    // sustained random write/drain with colliding commit and pop
    do_reset();
    base = rx_cnt;
    wn = 0;
    cyc = 0;
    while ((rx_cnt - base) < 8192 && cyc < 60000) begin
      w = 0;
      if (wn < 8192 && ((wn % PKT_LEN) != 0 || m_hs)) w = ($urandom_range(3, 0) != 0);
      s = (com.size() > 0) && ($urandom_range(1, 0) == 1);
      step(w, 16'(wn), s, 0);
      if (w) wn++;
      cyc++;
    end
    chk("rand_rx_count", 16'(rx_cnt - base), 16'd8192);
    chk("rand_last_word", last_rx, 16'd8191);
    chk("rand_no_ovr", tx_overrun, 16'h0);
    chk("rand_no_und", tx_underrun, 16'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/tx_buffer.md
TX_BUFFER -- requirements
Module: tx_buffer

Interface
REQ-001 SHALL have parameter PKT_LEN, default 256, words per host packet.
REQ-002 SHALL have parameter AW, default 10, FIFO address width, giving depth 2**AW words = 4 packets.
REQ-003 SHALL have port usbclk, input, 1 bit: the single clock; all logic SHALL be on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 SHALL have port usbdata, input, 16 bits: word from the host.
REQ-006 SHALL have port WR, input, 1 bit: host write strobe, one word per cycle while high.
REQ-007 SHALL have port have_space, output, 1 bit: at least PKT_LEN words are free.
REQ-008 SHALL have port tx_underrun, output, 1 bit: sticky underrun flag.
REQ-009 SHALL have port tx_overrun, output, 1 bit: sticky overrun flag.
REQ-010 SHALL have port clear_status, input, 1 bit: clears both sticky flags.
REQ-011 SHALL have port txstrobe, input, 1 bit: consumer requests one word.
REQ-012 SHALL have port txdata, output, 16 bits: drained word.
REQ-013 SHALL have port txvalid, output, 1 bit: one-cycle pulse, txdata is new.
REQ-014 SHALL have port debugbus, output, 16 bits: internal status.

Function
REQ-015 SHALL write usbdata into the FIFO on each cycle with WR high and the FIFO not full; a write-word counter SHALL wrap modulo PKT_LEN.
REQ-016 SHALL advance a committed write pointer by PKT_LEN on the cycle the last word of a packet is written; words of a partial packet SHALL NOT be readable.
REQ-017 SHALL drop a word presented with WR high while the FIFO is full, set tx_overrun, and leave the word counter unchanged.
REQ-018 SHALL register have_space as (2**AW - (wr_ptr - rd_ptr)) >= PKT_LEN, using raw pointers of AW+1 bits with natural wrap-around.
REQ-019 SHALL implement states IDLE and RUN; IDLE->RUN when committed words >= PKT_LEN; RUN->IDLE on underrun.
REQ-020 In RUN, txstrobe with committed data SHALL pop one word; txdata and txvalid SHALL update one cycle after txstrobe (latency 1).
REQ-021 txstrobe in RUN with zero committed words SHALL set tx_underrun, force txdata to 0 with txvalid low, and enter IDLE.
REQ-022 txstrobe in IDLE SHALL NOT pop, SHALL hold txdata at 0, and SHALL NOT set tx_underrun.
REQ-023 A commit and a pop in the same cycle SHALL both take effect.
REQ-024 clear_status SHALL clear both flags; a new flag event in the same cycle SHALL win (flag set).

Reset
REQ-025 While rst is high: pointers, word counter, txdata, txvalid, tx_underrun and tx_overrun SHALL be 0, state SHALL be IDLE, and have_space SHALL be 1 after release.
REQ-026 rst asserted mid-packet or mid-drain SHALL discard all FIFO contents, including any partial packet.

Configuration
REQ-027 With TX_BUFFER_DEBUG_EN defined, debugbus SHALL be {state, tx_overrun, tx_underrun, 4'b0, committed word count[8:0]}.
REQ-028 Without TX_BUFFER_DEBUG_EN, debugbus SHALL be tied to 0 and the debug logic SHALL be absent.

Structure
REQ-029 A shared package tx_buffer_pkg SHALL hold the PKT_LEN and AW defaults and the IDLE/RUN state encoding.
REQ-030 FIFO storage SHALL be a sub-module tx_dpram: 16-bit, 2**AW deep, one write port, registered read port, on usbclk.

Verification
REQ-031 Reset released; host writes 256 words 0..255 as WR bursts; txstrobe every 4th cycle -> txdata 0..255 in order, txvalid once per strobe, no flags.
REQ-032 Host writes 255 words, then txstrobe -> no txvalid, state IDLE; the 256th word is written -> the first txstrobe after it returns 0.
REQ-033 Host writes 1024 words with no drain -> have_space falls after word 768; a further write -> tx_overrun=1 and the word is dropped; clear_status -> 0.
REQ-034 One packet drained fully, then a 257th txstrobe -> tx_underrun=1, txdata=0, state IDLE; refilling a packet resumes from the next word.
REQ-035 rst pulsed mid-packet after 100 words -> FIFO empty, have_space=1; the next full packet is read from its first word.
REQ-036 Sustained write/drain for 8192 words with commit and pop colliding -> all words match an incrementing counter, no flags; run with and without TX_BUFFER_DEBUG_EN.
